// File: rtl/rob_commit_unit_if.sv
// Dispatch/writeback/retire bundle between the out-of-order core and the reorder buffer.
// master = core side (dispatch, FU pipes, rename), slave = the ROB itself.
interface rob_commit_unit_if #(
  parameter int TAG_W  = 4,
  parameter int PREG_W = 7
);
  logic              alloc_valid;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;
  logic              alloc_has_rd;
  logic [PREG_W-1:0] alloc_pd;
  logic [PREG_W-1:0] alloc_pd_old;
  logic [31:0]       alloc_pc;

  logic              alu_done;
  logic              b_done;
  logic              mem_done;
  logic [TAG_W-1:0]  alu_tag;
  logic [TAG_W-1:0]  b_tag;
  logic [TAG_W-1:0]  mem_tag;

  logic              mispredict;
  logic [TAG_W-1:0]  mispredict_tag;

  logic              commit_valid;
  logic              commit_has_rd;
  logic [PREG_W-1:0] commit_pd;
  logic [PREG_W-1:0] commit_pd_old;
  logic [31:0]       commit_pc;

  logic [TAG_W-1:0]  curr_rob_tag;
  logic [TAG_W:0]    count;
  logic              full;
  logic              empty;

  modport master (
    output alloc_valid, alloc_has_rd, alloc_pd, alloc_pd_old, alloc_pc,
    output alu_done, b_done, mem_done, alu_tag, b_tag, mem_tag,
    output mispredict, mispredict_tag,
    input  alloc_ready, alloc_tag,
    input  commit_valid, commit_has_rd, commit_pd, commit_pd_old, commit_pc,
    input  curr_rob_tag, count, full, empty
  );

  modport slave (
    input  alloc_valid, alloc_has_rd, alloc_pd, alloc_pd_old, alloc_pc,
    input  alu_done, b_done, mem_done, alu_tag, b_tag, mem_tag,
    input  mispredict, mispredict_tag,
    output alloc_ready, alloc_tag,
    output commit_valid, commit_has_rd, commit_pd, commit_pd_old, commit_pc,
    output curr_rob_tag, count, full, empty
  );
endinterface

// File: rtl/rob_commit_unit.sv
// Reorder buffer: in-order allocate, out-of-order completion by tag, in-order single retire,
// and squash of everything younger than a mispredicted branch.
module rob_commit_unit #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int PREG_W = 7
) (
  input logic             clk,
  input logic             reset,
  rob_commit_unit_if.slave rob
);
  localparam logic [TAG_W-1:0] TAG_ONE = TAG_W'(1);

  logic [DEPTH-1:0]  valid_q, done_q;
  logic [DEPTH-1:0]  valid_n, done_n;
  logic [DEPTH-1:0]  has_rd_q;
  logic [PREG_W-1:0] pd_q     [DEPTH];
  logic [PREG_W-1:0] pd_old_q [DEPTH];
  logic [31:0]       pc_q     [DEPTH];

  logic [TAG_W-1:0]  head_q, tail_q;
  logic [TAG_W:0]    count_q;

  logic              alloc_fire, commit_fire, mp_fire;
  logic [DEPTH-1:0]  squash, complete;
  logic [TAG_W-1:0]  young_n;

  assign rob.full         = (count_q == (TAG_W+1)'(DEPTH));
  assign rob.empty        = (count_q == '0);
  assign rob.alloc_ready  = !rob.full && !rob.mispredict;
  assign rob.alloc_tag    = tail_q;
  assign rob.curr_rob_tag = head_q;
  assign rob.count        = count_q;

  assign alloc_fire  = rob.alloc_valid && rob.alloc_ready;
  assign commit_fire = valid_q[head_q] && done_q[head_q];
  assign mp_fire     = rob.mispredict && valid_q[rob.mispredict_tag];

  // Number of entries strictly younger than the branch; the -1 form keeps the full-ROB case correct.
  assign young_n = tail_q - rob.mispredict_tag - TAG_ONE;

  always_comb begin
    squash   = '0;
    complete = '0;
    for (int i = 0; i < DEPTH; i++) begin
      squash[i]   = mp_fire && ((TAG_W'(i) - rob.mispredict_tag - TAG_ONE) < young_n);
      complete[i] = valid_q[i] && !squash[i] &&
                    ((rob.alu_done && (rob.alu_tag == TAG_W'(i))) ||
                     (rob.b_done   && (rob.b_tag   == TAG_W'(i))) ||
                     (rob.mem_done && (rob.mem_tag == TAG_W'(i))));
    end
  end

  always_comb begin
    valid_n = valid_q & ~squash;
    done_n  = (done_q | complete) & ~squash;
    if (mp_fire) begin
      done_n[rob.mispredict_tag] = 1'b1;
    end
    if (alloc_fire) begin
      valid_n[tail_q] = 1'b1;
      done_n[tail_q]  = 1'b0;
    end
    if (commit_fire) begin
      valid_n[head_q] = 1'b0;
      done_n[head_q]  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_n;
      done_q  <= done_n;
      head_q  <= commit_fire ? head_q + TAG_ONE : head_q;
      if (mp_fire) begin
        tail_q  <= rob.mispredict_tag + TAG_ONE;
        count_q <= {1'b0, rob.mispredict_tag - head_q} + (TAG_W+1)'(1)
                   - (TAG_W+1)'(commit_fire);
      end else begin
        tail_q  <= alloc_fire ? tail_q + TAG_ONE : tail_q;
        count_q <= count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(commit_fire);
      end
    end
  end

  // Payload needs no reset: it is only ever read behind a set valid bit.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      has_rd_q[tail_q] <= rob.alloc_has_rd;
      pd_q[tail_q]     <= rob.alloc_pd;
      pd_old_q[tail_q] <= rob.alloc_pd_old;
      pc_q[tail_q]     <= rob.alloc_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rob.commit_valid  <= 1'b0;
      rob.commit_has_rd <= 1'b0;
      rob.commit_pd     <= '0;
      rob.commit_pd_old <= '0;
      rob.commit_pc     <= '0;
    end else begin
      rob.commit_valid <= commit_fire;
      if (commit_fire) begin
        rob.commit_has_rd <= has_rd_q[head_q];
        rob.commit_pd     <= pd_q[head_q];
        rob.commit_pd_old <= pd_old_q[head_q];
        rob.commit_pc     <= pc_q[head_q];
      end
    end
  end
endmodule

// File: tb/tb_rob_commit_unit.sv
// Scoreboard bench for rob_commit_unit: retire records are queued at allocation and
// popped by an independent monitor on every commit pulse.
module tb_rob_commit_unit;
  localparam int DEPTH  = 16;
  localparam int TAG_W  = 4;
  localparam int PREG_W = 7;

  typedef struct packed {
    logic              has_rd;
    logic [PREG_W-1:0] pd;
    logic [PREG_W-1:0] pd_old;
    logic [31:0]       pc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rob_commit_unit_if #(.TAG_W(TAG_W), .PREG_W(PREG_W)) rob ();

  rob_commit_unit #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PREG_W(PREG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .rob   (rob)
  );

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic idle();
    rob.alloc_valid    = 1'b0;
    rob.alloc_has_rd   = 1'b0;
    rob.alloc_pd       = '0;
    rob.alloc_pd_old   = '0;
    rob.alloc_pc       = '0;
    rob.alu_done       = 1'b0;
    rob.b_done         = 1'b0;
    rob.mem_done       = 1'b0;
    rob.alu_tag        = '0;
    rob.b_tag          = '0;
    rob.mem_tag        = '0;
    rob.mispredict     = 1'b0;
    rob.mispredict_tag = '0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_alloc(input logic has_rd, input logic [PREG_W-1:0] pd,
                          input logic [PREG_W-1:0] pd_old, input logic [31:0] pc,
                          input int tag);
    exp_t e;
    rob.alloc_valid  = 1'b1;
    rob.alloc_has_rd = has_rd;
    rob.alloc_pd     = pd;
    rob.alloc_pd_old = pd_old;
    rob.alloc_pc     = pc;
    #1;
    check("alloc_ready", rob.alloc_ready, 1);
    check("alloc_tag", rob.alloc_tag, tag);
    e = {has_rd, pd, pd_old, pc};
    exp_q.push_back(e);
    tick();
    rob.alloc_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int budget);
    for (int i = 0; i < budget && rob.empty !== 1'b1; i++) tick();
    check(name, rob.empty, 1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " empty"}, rob.empty, 1);
    check({tag, " full"}, rob.full, 0);
    check({tag, " count"}, rob.count, 0);
    check({tag, " alloc_ready"}, rob.alloc_ready, 1);
    check({tag, " alloc_tag"}, rob.alloc_tag, 0);
    check({tag, " curr_rob_tag"}, rob.curr_rob_tag, 0);
    check({tag, " commit_valid"}, rob.commit_valid, 0);
  endtask

  // Monitor: every retire pulse must match the oldest outstanding record.
  initial begin
    exp_t got, e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && rob.commit_valid === 1'b1) begin
        got = {rob.commit_has_rd, rob.commit_pd, rob.commit_pd_old, rob.commit_pc};
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL commit unexpected: actual %0h required none", got);
        end else begin
          e = exp_q.pop_front();
          check("commit record", got, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit accepted;
    idle();
    reset = 1'b1;
    #2;
    check_reset_state("reset");
    tick();
    reset = 1'b0;

    // Mid-run asynchronous reset with 5 entries in flight
    for (int i = 0; i < 5; i++)
      do_alloc(1'b1, PREG_W'(40 + i), PREG_W'(10 + i), 32'h100 + 32'(4 * i), i);
    check("pre-reset count", rob.count, 5);
    #2 reset = 1'b1;
    #1;
    check_reset_state("async reset");
    exp_q.delete();
    tick();
    reset = 1'b0;

    // In-order retire with out-of-order completion
    for (int i = 0; i < 3; i++)
      do_alloc(1'b1, PREG_W'(33 + i), PREG_W'(1 + i), 32'h1000 + 32'(4 * i), i);
    rob.alu_done = 1'b1;
    rob.alu_tag  = 4'd2; tick();
    rob.alu_tag  = 4'd0; tick();
    rob.alu_tag  = 4'd1; tick();
    rob.alu_done = 1'b0;
    check("t2 pulse0", rob.commit_valid, 1);
    check("t2 pd_old0", rob.commit_pd_old, 1);
    tick();
    check("t2 pulse1", rob.commit_valid, 1);
    check("t2 pd_old1", rob.commit_pd_old, 2);
    tick();
    check("t2 pulse2", rob.commit_valid, 1);
    check("t2 pd_old2", rob.commit_pd_old, 3);
    check("t2 count", rob.count, 0);

    // Fill to full, blocked 17th alloc, wrap after one retire
    pulse_reset();
    for (int i = 0; i < 16; i++)
      do_alloc(1'b1, PREG_W'(64 + i), PREG_W'(i), 32'h2000 + 32'(4 * i), i);
    check("t3 full", rob.full, 1);
    check("t3 alloc_ready", rob.alloc_ready, 0);
    check("t3 count16", rob.count, 16);
    rob.alloc_valid  = 1'b1;
    rob.alloc_has_rd = 1'b1;
    rob.alloc_pd     = 7'd100;
    rob.alloc_pd_old = 7'd50;
    rob.alloc_pc     = 32'h3000;
    tick();
    tick();
    check("t3 held not accepted", rob.count, 16);
    rob.alu_done = 1'b1;
    rob.alu_tag  = 4'd0;
    tick();
    rob.alu_done = 1'b0;
    accepted = 1'b0;
    for (int k = 0; k < 10 && !accepted; k++) begin
      #1;
      if (rob.alloc_ready === 1'b1) begin
        check("t3 wrap tag", rob.alloc_tag, 0);
        exp_q.push_back(exp_t'({1'b1, 7'd100, 7'd50, 32'h3000}));
        accepted = 1'b1;
      end
      tick();
    end
    rob.alloc_valid = 1'b0;
    check("t3 wrap accepted", accepted, 1);
    check("t3 full again", rob.full, 1);
    for (int i = 1; i <= 16; i++) begin
      rob.alu_done = 1'b1;
      rob.alu_tag  = TAG_W'(i);
      tick();
    end
    rob.alu_done = 1'b0;
    wait_empty("t3 drain", 40);

    // Mispredict on tag 2 with a same-cycle completion to a squashed tag
    pulse_reset();
    for (int i = 0; i < 6; i++)
      do_alloc(1'b1, PREG_W'(20 + i), PREG_W'(5 + i), 32'h4000 + 32'(4 * i), i);
    rob.mispredict     = 1'b1;
    rob.mispredict_tag = 4'd2;
    rob.alu_done       = 1'b1;
    rob.alu_tag        = 4'd4;
    #1;
    check("t4 alloc_ready mp", rob.alloc_ready, 0);
    tick();
    idle();
    for (int i = 0; i < 3; i++) void'(exp_q.pop_back());
    check("t4 count", rob.count, 3);
    check("t4 alloc_tag", rob.alloc_tag, 3);
    do_alloc(1'b1, 7'd50, 7'd12, 32'h5000, 3);
    do_alloc(1'b1, 7'd51, 7'd13, 32'h5004, 4);
    rob.alu_done = 1'b1;
    rob.alu_tag  = 4'd0; tick();
    rob.alu_tag  = 4'd1; tick();
    rob.alu_tag  = 4'd3; tick();
    rob.alu_done = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("t4 tag4 pending count", rob.count, 1);
    check("t4 head at 4", rob.curr_rob_tag, 4);
    rob.alu_done = 1'b1;
    rob.alu_tag  = 4'd4;
    tick();
    rob.alu_done = 1'b0;
    wait_empty("t4 drain", 10);

    // Three completions in one cycle, three back-to-back retires
    pulse_reset();
    for (int i = 0; i < 3; i++)
      do_alloc(1'b1, PREG_W'(60 + i), PREG_W'(30 + i), 32'h6000 + 32'(4 * i), i);
    rob.b_done   = 1'b1; rob.b_tag   = 4'd0;
    rob.alu_done = 1'b1; rob.alu_tag = 4'd1;
    rob.mem_done = 1'b1; rob.mem_tag = 4'd2;
    tick();
    idle();
    check("t5 no pulse yet", rob.commit_valid, 0);
    tick(); check("t5 pulse0", rob.commit_valid, 1);
    tick(); check("t5 pulse1", rob.commit_valid, 1);
    tick(); check("t5 pulse2", rob.commit_valid, 1);
    tick(); check("t5 pulse end", rob.commit_valid, 0);
    check("t5 empty", rob.empty, 1);

    // Store without rd, then a stray completion to an empty slot
    do_alloc(1'b0, 7'd9, 7'd8, 32'h7000, 3);
    rob.mem_done = 1'b1;
    rob.mem_tag  = 4'd3;
    tick();
    idle();
    tick();
    check("t6 store commit", rob.commit_valid, 1);
    check("t6 store has_rd", rob.commit_has_rd, 0);
    check("t6 count", rob.count, 0);
    rob.alu_done = 1'b1;
    rob.alu_tag  = 4'd9;
    tick();
    idle();
    tick();
    tick();
    check("t6 stray count", rob.count, 0);
    check("t6 stray empty", rob.empty, 1);
    check("t6 stray no commit", rob.commit_valid, 0);

    check("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
